// File: rtl/nios2_oci_trace_pkg.sv
// Shared state encoding, status flags and sizing helpers for the OCI trace capture block.
package nios2_oci_trace_pkg;

  localparam int TOTAL_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    UNPACK,
    FROZEN
  } state_t;

  typedef struct packed {
    logic wrapped;
    logic overflow;
    logic err_count;
    logic truncated;
  } flags_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/nios2_oci_trace_ram.sv
// Simple dual-port capture RAM: synchronous write, registered read (1-cycle latency).
// Contents are never reset; the top masks reads of unwritten entries.
module nios2_oci_trace_ram #(
  parameter int DEPTH   = 64,
  parameter int FIELD_W = 10,
  parameter int AW      = 6
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [FIELD_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [FIELD_W-1:0] rdata
);

  logic [FIELD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Trace sink: unpacks one field per cycle into a DEPTH-entry buffer, busy (dct_ready=0) while unpacking.
// Freezes on test end and exposes the buffer, oldest first; OCI_TRACE_CHECKSUM_EN adds a running XOR checksum.
module nios2_oci_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int FIELD_W = 10,
  parameter int SLOTS   = 3,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 64,
  parameter int WRAP    = 1,
  localparam int PW     = ptr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SLOTS*FIELD_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     dct_valid,
  output logic                     dct_ready,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  input  logic [PW-1:0]            rd_addr,
  output logic [FIELD_W-1:0]       rd_data,
  output logic                     frozen,
  output logic [PW:0]              fill_level,
  output logic [TOTAL_W-1:0]       total_cnt,
`ifdef OCI_TRACE_CHECKSUM_EN
  output logic [FIELD_W-1:0]       checksum,
`endif
  output logic                     wrapped,
  output logic                     overflow,
  output logic                     err_count,
  output logic                     truncated
);

  localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PW:0]      DEPTH_C = (PW+1)'(DEPTH);

  state_t                   state, state_nxt;
  logic                     alive;
  logic [SLOTS*FIELD_W-1:0] word_q;
  logic [CNT_W-1:0]         rem_q;
  logic                     pend_q;
  logic [PW-1:0]            wr_ptr;
  logic [PW:0]              fill;
  logic [TOTAL_W-1:0]       total;
  flags_t                   flags;
  logic                     rd_ok;

  logic                     hs, field_vld, load, cut, full, we, freeze_pend;
  logic [CNT_W-1:0]         k;
  logic [FIELD_W-1:0]       field_dat, ram_rdata;
  logic [PW-1:0]            oldest, raddr;

  assign k           = (dct_count > SLOTS_C) ? SLOTS_C : dct_count;
  assign freeze_pend = pend_q | test_ending;
  assign full        = (fill == DEPTH_C);
  assign we          = field_vld & ((WRAP != 0) | ~full);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    dct_ready = 1'b0;
    hs        = 1'b0;
    field_vld = 1'b0;
    field_dat = dct_buffer[FIELD_W-1:0];
    load      = 1'b0;
    cut       = 1'b0;
    case (state)
      IDLE: begin
        dct_ready = alive;
        hs        = dct_valid & alive;
        field_vld = hs & (k != '0);
        // An immediate freeze still lets field 0 of a same-cycle word land.
        if (test_has_ended) begin
          state_nxt = FROZEN;
          cut       = hs & (k > ONE_C);
        end else if (hs && k > ONE_C) begin
          state_nxt = UNPACK;
          load      = 1'b1;
        end else if (freeze_pend) begin
          state_nxt = FROZEN;
        end
      end
      UNPACK: begin
        field_dat = word_q[FIELD_W-1:0];
        if (test_has_ended) begin
          state_nxt = FROZEN;
          cut       = 1'b1;
        end else begin
          field_vld = 1'b1;
          if (rem_q == ONE_C) state_nxt = freeze_pend ? FROZEN : IDLE;
        end
      end
      FROZEN: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      rem_q  <= '0;
      pend_q <= 1'b0;
      wr_ptr <= '0;
      fill   <= '0;
      total  <= '0;
      flags  <= '0;
      rd_ok  <= 1'b0;
    end else begin
      // word_q holds the not-yet-written fields with the next one in the low bits.
      if (load) begin
        word_q <= dct_buffer >> FIELD_W;
        rem_q  <= k - ONE_C;
      end else if (state == UNPACK) begin
        word_q <= word_q >> FIELD_W;
        rem_q  <= rem_q - ONE_C;
      end
      if (test_ending) pend_q <= 1'b1;
      if (hs && dct_count > SLOTS_C) flags.err_count <= 1'b1;
      if (cut) flags.truncated <= 1'b1;
      if (field_vld) begin
        if (total != '1) total <= total + TOTAL_W'(1);
        if (!we) begin
          flags.overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + PW'(1);
          if (full) flags.wrapped <= 1'b1;
          else      fill <= fill + (PW+1)'(1);
        end
      end
      rd_ok <= (state == FROZEN) && ({1'b0, rd_addr} < fill);
    end
  end

  // Once wrapped, the write pointer sits on the oldest surviving entry.
  assign oldest = ((WRAP != 0) && flags.wrapped) ? wr_ptr : '0;
  assign raddr  = rd_addr + oldest;

  nios2_oci_trace_ram #(
    .DEPTH   (DEPTH),
    .FIELD_W (FIELD_W),
    .AW      (PW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (field_dat),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

`ifdef OCI_TRACE_CHECKSUM_EN
  logic [FIELD_W-1:0] csum;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  csum <= '0;
    else if (we)   csum <= csum ^ field_dat;
  end
  assign checksum = csum;
`endif

  assign rd_data    = rd_ok ? ram_rdata : '0;
  assign frozen     = (state == FROZEN);
  assign fill_level = fill;
  assign total_cnt  = total;
  assign wrapped    = flags.wrapped;
  assign overflow   = flags.overflow;
  assign err_count  = flags.err_count;
  assign truncated  = flags.truncated;

endmodule
